// File: rtl/uart_send_buffer_pkg.sv
// Shared types for the UART transmit path: byte/word aliases, the send FSM
// state encoding and a little-endian byte select helper.
package uart_send_buffer_pkg;

    typedef logic [7:0]  w8;
    typedef logic [31:0] w32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    function automatic w8 select_byte(input w32 word, input logic [1:0] idx);
        return w8'(word >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/send_fifo.sv
// Word FIFO feeding the UART serialiser: storage, wrap-around pointers,
// occupancy count, registered full flag and sticky overflow.
module send_fifo
    import uart_send_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [31:0]           push_data,
    input  logic                  pop,
    output logic [31:0]           head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    w32                    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop;

    always_comb begin
        // A push while full is dropped even if a pop frees a slot this cycle.
        do_push    = push && !full_q;
        do_pop     = pop && (count_q != '0);
        head_d     = do_pop  ? head_q + PTR_ONE : head_q;
        tail_d     = do_push ? tail_q + PTR_ONE : tail_q;
        overflow_d = overflow_q || (push && full_q);
        count_d    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail_q] <= push_data;
    end

    assign head_data = mem[head_q];
    assign count     = count_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/uart_send_buffer.sv
// Buffers 32-bit words from the core and serialises the low WORD_BYTES bytes,
// byte 0 first, into UartTx via its tx_start/tx_busy handshake.
module uart_send_buffer
    import uart_send_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WORD_BYTES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] wd,
    output logic        full,
    output logic        overflow,
    input  logic        inhibit,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  sdata
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    tx_state_t           state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                wait_cnt_q, wait_cnt_d;
    w8                   sdata_q, sdata_d;
    logic                pop;
    w32                  head_word;
    logic [DEPTH_LOG2:0] count;

    send_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (we),
        .push_data (wd),
        .pop       (pop),
        .head_data (head_word),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_cnt_q <= 1'b0;
            sdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            sdata_q    <= sdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        sdata_d    = sdata_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                // Inhibit only gates new bytes, so a word may pause between bytes.
                if (count != '0 && !inhibit && !tx_busy) begin
                    state_d = START;
                    sdata_d = select_byte(head_word, idx_q);
                end
            end
            START: begin
                state_d    = WAIT_HI;
                wait_cnt_d = 1'b0;
            end
            WAIT_HI: begin
                // Second cycle without busy: assume UartTx took the byte anyway.
                if (tx_busy || wait_cnt_q) state_d = WAIT_LO;
                else                       wait_cnt_d = 1'b1;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (idx_q == LAST_IDX) begin
                        pop   = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == START);
    end

    assign sdata = sdata_q;

endmodule

// File: tb/tb_uart_send_buffer.sv
// Scoreboard bench: two instances (1-byte/depth-4 and 4-byte/depth-16), each
// with a mock UartTx; a negedge monitor pops expected bytes on every tx_start.
module tb_uart_send_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        we_a, we_b, inhibit_a, inhibit_b;
    logic [31:0] wd_a, wd_b;
    logic        full_a, full_b, overflow_a, overflow_b;
    logic        tx_busy_a, tx_busy_b, tx_start_a, tx_start_b;
    logic [7:0]  sdata_a, sdata_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   starts_a = 0, starts_b = 0;
    int   busy_len_a = 20, busy_len_b = 5;
    int   busy_cnt_a = 0, busy_cnt_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clock = ~clock;

    uart_send_buffer #(.DEPTH_LOG2(2), .WORD_BYTES(1)) dut_a (
        .clock(clock), .reset(reset), .we(we_a), .wd(wd_a), .full(full_a),
        .overflow(overflow_a), .inhibit(inhibit_a), .tx_busy(tx_busy_a),
        .tx_start(tx_start_a), .sdata(sdata_a)
    );

    uart_send_buffer #(.DEPTH_LOG2(4), .WORD_BYTES(4)) dut_b (
        .clock(clock), .reset(reset), .we(we_b), .wd(wd_b), .full(full_b),
        .overflow(overflow_b), .inhibit(inhibit_b), .tx_busy(tx_busy_b),
        .tx_start(tx_start_b), .sdata(sdata_b)
    );

    // Mock UartTx: busy rises the cycle after tx_start and lasts busy_len cycles.
    assign tx_busy_a = hold_a | (busy_cnt_a != 0);
    assign tx_busy_b = hold_b | (busy_cnt_b != 0);

    always @(posedge clock) begin
        if (tx_start_a)          busy_cnt_a <= busy_len_a;
        else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
        if (tx_start_b)          busy_cnt_b <= busy_len_b;
        else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (tx_start_a) begin
            starts_a++;
            check("a_busy_clear_at_start", 32'(tx_busy_a), 32'd0);
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_start: sdata 0x%0h, no byte expected", sdata_a);
            end else check("a_sdata", 32'(sdata_a), 32'(exp_a.pop_front()));
        end
        if (tx_start_b) begin
            starts_b++;
            check("b_busy_clear_at_start", 32'(tx_busy_b), 32'd0);
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_start: sdata 0x%0h, no byte expected", sdata_b);
            end else check("b_sdata", 32'(sdata_b), 32'(exp_b.pop_front()));
        end
    end

    task automatic push_a(input logic [31:0] w);
        we_a = 1'b1; wd_a = w;
        @(negedge clock);
        we_a = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] w);
        we_b = 1'b1; wd_b = w;
        @(negedge clock);
        we_b = 1'b0;
    endtask

    task automatic drain(input int which, input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            if (which == 0 ? (exp_a.size() == 0 && !tx_busy_a)
                           : (exp_b.size() == 0 && !tx_busy_b)) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
        repeat (30) @(negedge clock);
    endtask

    task automatic wait_busy(input int which, input logic level, input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if ((which == 0 ? tx_busy_a : tx_busy_b) == level) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, 0x0 of 0x1 runs completed");
        $fatal(1);
    end

    initial begin
        int  s;
        logic seen;
        reset = 1'b1;
        we_a = 1'b0; we_b = 1'b0; wd_a = '0; wd_b = '0;
        inhibit_a = 1'b0; inhibit_b = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_full_a",     32'(full_a),     32'd0);
        check("rst_overflow_a", 32'(overflow_a), 32'd0);
        check("rst_tx_start_a", 32'(tx_start_a), 32'd0);
        check("rst_sdata_a",    32'(sdata_a),    32'd0);
        check("rst_full_b",     32'(full_b),     32'd0);
        check("rst_overflow_b", 32'(overflow_b), 32'd0);
        check("rst_tx_start_b", 32'(tx_start_b), 32'd0);
        check("rst_sdata_b",    32'(sdata_b),    32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: single byte, latency t+2, no second pulse
        s = starts_a;
        exp_a.push_back(8'hA5);
        push_a(32'h0000_00A5);
        check("t1_no_start_at_t1", 32'(tx_start_a), 32'd0);
        @(negedge clock);
        check("t1_start_at_t2", 32'(tx_start_a), 32'd1);
        check("t1_sdata_at_t2", 32'(sdata_a), 32'hA5);
        drain(0, "t1_drain");
        check("t1_count_empty", 32'(dut_a.u_fifo.count_q), 32'd0);
        check("t1_pulses", 32'(starts_a - s), 32'd1);

        // 2: four bytes, little-endian
        s = starts_b;
        exp_b.push_back(8'h11); exp_b.push_back(8'h22);
        exp_b.push_back(8'h33); exp_b.push_back(8'h44);
        push_b(32'h4433_2211);
        drain(1, "t2_drain");
        check("t2_pulses", 32'(starts_b - s), 32'd4);
        check("t2_count_empty", 32'(dut_b.u_fifo.count_q), 32'd0);

        // 3: fill depth-4 FIFO while busy held, fifth push overflows
        hold_a = 1'b1;
        busy_len_a = 3;
        for (int i = 1; i <= 4; i++) begin
            exp_a.push_back(8'(8'h10 + i));
            push_a(32'h0000_0010 + i);
            check("t3_full_progress", 32'(full_a), (i == 4) ? 32'd1 : 32'd0);
        end
        check("t3_no_overflow_yet", 32'(overflow_a), 32'd0);
        push_a(32'h0000_0015);
        check("t3_overflow", 32'(overflow_a), 32'd1);
        check("t3_still_full", 32'(full_a), 32'd1);
        s = starts_a;
        hold_a = 1'b0;
        drain(0, "t3_drain");
        check("t3_pulses", 32'(starts_a - s), 32'd4);
        check("t3_overflow_sticky", 32'(overflow_a), 32'd1);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t3_reset_overflow", 32'(overflow_a), 32'd0);

        // 4: inhibit holds off the start
        inhibit_a = 1'b1;
        s = starts_a;
        push_a(32'h0000_005A);
        repeat (50) @(negedge clock);
        check("t4_inhibited", 32'(starts_a - s), 32'd0);
        exp_a.push_back(8'h5A);
        inhibit_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (tx_start_a) begin seen = 1'b1; break; end
        end
        check("t4_start_after_release", 32'(seen), 32'd1);
        drain(0, "t4_drain");

        // 5: push dropped in the same cycle the head is popped
        hold_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_a.push_back(8'(8'h20 + i));
            push_a(32'h0000_0020 + i);
        end
        check("t5_full", 32'(full_a), 32'd1);
        hold_a = 1'b0;
        wait_busy(0, 1'b1, "t5_busy_rise");
        wait_busy(0, 1'b0, "t5_busy_fall");
        push_a(32'h0000_0099);
        check("t5_overflow", 32'(overflow_a), 32'd1);
        check("t5_not_full", 32'(full_a), 32'd0);
        check("t5_count", 32'(dut_a.u_fifo.count_q), 32'd3);
        drain(0, "t5_drain");

        // 6: reset during WAIT_LO of a 4-byte word
        exp_b.push_back(8'hAA);
        push_b(32'hDDCC_BBAA);
        wait_busy(1, 1'b1, "t6_busy_rise");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_tx_start", 32'(tx_start_b), 32'd0);
        check("t6_full", 32'(full_b), 32'd0);
        check("t6_overflow_b", 32'(overflow_b), 32'd0);
        check("t6_overflow_a_cleared", 32'(overflow_a), 32'd0);
        s = starts_b;
        repeat (20) @(negedge clock);
        check("t6_no_more_bytes", 32'(starts_b - s), 32'd0);
        exp_b.push_back(8'hC3); exp_b.push_back(8'h00);
        exp_b.push_back(8'h00); exp_b.push_back(8'h00);
        push_b(32'h0000_00C3);
        drain(1, "t6_drain");
        check("t6_pulses", 32'(starts_b - s), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_send_buffer.md
Name: uart_send_buffer

Overview:
- Transmit-side counterpart of the boot/receive path.
- Accepts 32-bit words from the core's send request (en/content/busy) and buffers them in a FIFO.
- Serialises each word into bytes, little-endian, and drives UartTx through its tx_start/tx_busy handshake.
- Replaces the direct core-to-UartTx glue. The BootLoader can pause draining through an inhibit input so the two never collide on UartTx.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words.
- WORD_BYTES, 1: number of low-order bytes sent per word, legal range 1..4. Byte 0 (bits 7:0) is sent first.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- we  input  1  push request from the core (send_from_core.en)
- wd  input  32  word to push (send_from_core.content)
- full  output  1  FIFO full; drives send_from_core.busy
- overflow  output  1  sticky: a push arrived while full
- inhibit  input  1  when 1, no new byte is started (BootLoader owns UartTx)
- tx_busy  input  1  UartTx busy
- tx_start  output  1  one-cycle start pulse to UartTx
- sdata  output  8  byte to UartTx; valid while tx_start=1

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: full=0, overflow=0, tx_start=0, sdata=0, FIFO empty (count=0, head=tail=0), FSM=IDLE, byte index=0.
- Reset mid-transmission: the FIFO and FSM clear immediately. A byte already handed to UartTx finishes on its own. No further tx_start is issued until new data is pushed.
- FIFO storage:
  - count register is DEPTH_LOG2+1 bits; head and tail pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - full = (count == 2**DEPTH_LOG2), registered from count.
  - Push with we=1 and full=0: write wd at tail, tail+1.
  - Push with we=1 and full=1: word dropped; overflow set to 1 and held until reset. This applies even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- FSM states are IDLE, START, WAIT_HI, WAIT_LO:
  - IDLE: if count!=0, inhibit=0 and tx_busy=0, go to START. In the same cycle, register sdata = byte[idx] of the head word; idx is 0 for a fresh word.
  - START: tx_start=1 for exactly this cycle; go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. UartTx asserts busy the cycle after tx_start. If tx_busy is still 0 after 2 cycles, treat the byte as accepted and go to WAIT_LO anyway.
  - WAIT_LO: wait for tx_busy=0.
    - If idx==WORD_BYTES-1: pop the head (head+1, count-1), set idx=0, go to IDLE.
    - Otherwise: idx+1, go to IDLE.
- inhibit only gates the IDLE-to-START transition. A word already in progress is paused between bytes, never mid-byte.
- Latency: a push at cycle t into an empty, idle buffer (inhibit=0, tx_busy=0) gives tx_start=1 at cycle t+2.
- The head word is read combinationally from storage while FSM=IDLE. It is stable while queued because pushes never write the head slot when count>0.
- sdata holds its value between starts.

Decomposition:
- w8 and w32 come from the shared typedefs.svh package.
- Add a shared send-FSM state enum, tx_state_t, alongside them.
- One sub-module: send_fifo. It holds storage, pointers, count, full and overflow, with push/pop/head ports. The FSM and byte serialiser stay in uart_send_buffer.
- Board wiring:
  - tx_start into UartTx = bootloader tx_start | tx_start.
  - inhibit = BootLoader activity, i.e. ~program_loaded.

Test Plan:
1. After reset, push 0x000000A5 with WORD_BYTES=1 and a mock UartTx busy for 20 cycles. Expect tx_start at t+2 with sdata=0xA5, count back to 0 after busy falls, and no second pulse.
2. WORD_BYTES=4, push 0x44332211. Expect four tx_start pulses with sdata 0x11, 0x22, 0x33, 0x44, each one issued only after the previous busy falls.
3. DEPTH_LOG2=2, hold tx_busy=1, push 5 words. Expect full=1 after the 4th push, the 5th word dropped and overflow=1. Release busy: exactly 4 bytes are sent, in order.
4. Hold inhibit=1 and push 0x5A. Expect no tx_start for 50 cycles. Drop inhibit: tx_start with 0x5A follows within 2 cycles.
5. With a full FIFO, do a simultaneous pop and push. Expect the push dropped, overflow=1, and count = depth-1.
6. Pulse reset during WAIT_LO of a 4-byte word. Expect tx_start=0, full=0, overflow=0, and no further bytes. A new push of 0x000000C3 then sends 0xC3 first.
